// File: rtl/id_ex_pipe_pkg.sv
// Shared decode constants and the control bundle carried from ID into EX.
// Types and constants only; no timing or flow-control behaviour here.
package id_ex_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   reg_dst;
    logic   alu_src;
    logic   alu_src2;
    logic   mem_to_reg;
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    logic   branch;
    aluop_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Any bit that can change architectural state once the instruction retires.
  function automatic logic ctrl_has_side_effect(input ctrl_t c);
    return c.reg_write | c.mem_write | c.mem_read | c.branch;
  endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard check between the load in EX and the instruction in ID.
// Purely combinational (zero latency); output is the upstream freeze request.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use_stall
);

  logic ex_is_load;
  logic rs_match;
  logic rt_match;

  // r0 is hard-wired zero, so a load targeting it never produces a value to wait for.
  assign ex_is_load = ex_valid & ex_mem_read & (ex_rt != '0);
  assign rs_match   = (ex_rt == id_rs);
  assign rt_match   = id_uses_rt & (ex_rt == id_rt);

  assign load_use_stall = ex_is_load & id_valid & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, flush and saturating bubble count.
// 1-cycle latency; Stall holds everything, a load-use hazard freezes upstream and inserts one bubble.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              Stall,
  input  logic              ID_Valid,
  input  logic              ID_RegDst,
  input  logic              ID_ALUSrc,
  input  logic              ID_ALUSrc2,
  input  logic              ID_MemtoReg,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_Branch,
  input  logic [1:0]        ID_ALUOp,
  input  logic              ID_UsesRt,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_SignExt,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  output logic              EX_RegDst,
  output logic              EX_ALUSrc,
  output logic              EX_ALUSrc2,
  output logic              EX_MemtoReg,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_Branch,
  output logic [1:0]        EX_ALUOp,
  output logic [DATA_W-1:0] EX_PC4,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_SignExt,
  output logic [REG_W-1:0]  EX_Rs,
  output logic [REG_W-1:0]  EX_Rt,
  output logic [REG_W-1:0]  EX_Rd,
  output logic              EX_Valid,
  output logic              LoadUseStall,
  output logic [CNT_W-1:0]  BubbleCount
);

  ctrl_t             id_ctrl;
  ctrl_t             ex_ctrl;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_sext;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic [CNT_W-1:0]  bubble_cnt;
  logic              load_use;
  logic              do_bubble;
  logic              do_load;

  always_comb begin
    id_ctrl            = CTRL_NOP;
    id_ctrl.reg_dst    = ID_RegDst;
    id_ctrl.alu_src    = ID_ALUSrc;
    id_ctrl.alu_src2   = ID_ALUSrc2;
    id_ctrl.mem_to_reg = ID_MemtoReg;
    id_ctrl.reg_write  = ID_RegWrite;
    id_ctrl.mem_read   = ID_MemRead;
    id_ctrl.mem_write  = ID_MemWrite;
    id_ctrl.branch     = ID_Branch;
    id_ctrl.alu_op     = aluop_e'(ID_ALUOp);
  end

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_ctrl.mem_read),
    .ex_rt          (ex_rt),
    .id_valid       (ID_Valid),
    .id_rs          (ID_Rs),
    .id_rt          (ID_Rt),
    .id_uses_rt     (ID_UsesRt),
    .load_use_stall (load_use)
  );

  // Flush beats Stall so a squash is never lost; Stall beats the hazard so no bubble is counted while frozen.
  assign do_bubble = Flush | (~Stall & load_use);
  assign do_load   = ~Flush & ~Stall & ~load_use;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_ctrl  <= CTRL_NOP;
      ex_valid <= 1'b0;
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_sext  <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else if (do_bubble) begin
      ex_ctrl  <= CTRL_NOP;
      ex_valid <= 1'b0;
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_sext  <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else if (do_load) begin
      ex_ctrl  <= id_ctrl;
      ex_valid <= ID_Valid;
      ex_pc4   <= ID_PC4;
      ex_rd1   <= ID_ReadData1;
      ex_rd2   <= ID_ReadData2;
      ex_sext  <= ID_SignExt;
      ex_rs    <= ID_Rs;
      ex_rt    <= ID_Rt;
      ex_rd    <= ID_Rd;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bubble_cnt <= '0;
    end else if (do_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign EX_RegDst    = ex_ctrl.reg_dst;
  assign EX_ALUSrc    = ex_ctrl.alu_src;
  assign EX_ALUSrc2   = ex_ctrl.alu_src2;
  assign EX_MemtoReg  = ex_ctrl.mem_to_reg;
  assign EX_RegWrite  = ex_ctrl.reg_write;
  assign EX_MemRead   = ex_ctrl.mem_read;
  assign EX_MemWrite  = ex_ctrl.mem_write;
  assign EX_Branch    = ex_ctrl.branch;
  assign EX_ALUOp     = ex_ctrl.alu_op;
  assign EX_PC4       = ex_pc4;
  assign EX_ReadData1 = ex_rd1;
  assign EX_ReadData2 = ex_rd2;
  assign EX_SignExt   = ex_sext;
  assign EX_Rs        = ex_rs;
  assign EX_Rt        = ex_rt;
  assign EX_Rd        = ex_rd;
  assign EX_Valid     = ex_valid;
  assign LoadUseStall = load_use;
  assign BubbleCount  = bubble_cnt;

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register sitting directly downstream of the main decode/control unit.
- Captures the decoded control bundle, register-file read data, sign-extended immediate and register specifiers, then presents them to EX one cycle later.
- Contains load-use hazard detection that requests an upstream freeze and inserts a bubble.
- Supports flush on taken branch and a global pipeline stall.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- DATA_W, 32, width of datapath words (PC+4, read data, immediate)
- REG_W, 5, register specifier width
- CNT_W, 16, bubble counter width

Ports:
- Clk  input  1  pipeline clock, all state on rising edge
- Rst  input  1  asynchronous, active-low reset
- Flush  input  1  taken-branch squash of the instruction entering EX
- Stall  input  1  global freeze (e.g. memory wait); hold all state
- ID_Valid  input  1  ID holds a real instruction
- ID_RegDst, ID_ALUSrc, ID_ALUSrc2, ID_MemtoReg, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_Branch  input  1 each  decoded control bits
- ID_ALUOp  input  2  ALU operation class
- ID_UsesRt  input  1  ID instruction reads Rt as a source operand
- ID_PC4, ID_ReadData1, ID_ReadData2, ID_SignExt  input  DATA_W each  datapath operands
- ID_Rs, ID_Rt, ID_Rd  input  REG_W each  register specifiers
- EX_* (one per ID_* above except ID_UsesRt)  output  same widths  registered copies
- EX_Valid  output  1  EX holds a real instruction
- LoadUseStall  output  1  combinational; freeze PC and IF/ID this cycle
- BubbleCount  output  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (Rst=0, async):
  - All EX_* outputs, EX_Valid and BubbleCount go to 0.
  - LoadUseStall evaluates to 0 because EX_Valid=0.
- Hazard (combinational):
  - LoadUseStall = EX_Valid & EX_MemRead & ID_Valid & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & EX_Rt == ID_Rt)).
- Per rising edge, first matching case wins:
  1. Flush=1 → bubble.
  2. Stall=1 → hold every register, including BubbleCount.
  3. LoadUseStall=1 → bubble.
  4. Otherwise → load every EX_* from ID_*, and EX_Valid <= ID_Valid.
- Bubble:
  - EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch, EX_Valid <= 0.
  - All other control bits and ALUOp <= 0.
  - Datapath and specifier fields <= 0.
  - BubbleCount increments by 1, saturating at all-ones (no wrap).
- Flush asserted together with Stall: Flush wins, because a squash must never be lost.
- Stall asserted together with LoadUseStall: hold, and no bubble is counted. The hazard re-evaluates once Stall drops.
- Latency: exactly 1 cycle from ID to EX when no stall, flush or hazard applies.
- Load-use dead time: the hazard resolves after exactly one bubble. On the next cycle EX holds the bubble (EX_MemRead=0), so the waiting instruction proceeds.
- Register 0 is never a hazard source.
- ID_Valid=0 still loads: controls pass through, but EX_Valid=0. EX treats the instruction as a NOP regardless of its control bits. EX writeback must gate RegWrite, MemWrite and MemRead with EX_Valid.
- Reset mid-stall or mid-bubble: async clear takes effect immediately. No pending hazard survives reset.

Decomposition:
- Shared package holds:
  - opcode constants (R-type 000000, LW 100011, SW 101011, BEQ 000100);
  - ALUOp encodings (00 add, 01 sub/branch, 10 funct);
  - a typedef for the control bundle (RegDst, ALUSrc, ALUSrc2, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp).
- One sub-module, hazard_detect, holds the pure combinational LoadUseStall equation. It is reused later by the forwarding work.
- The register and counter stay in id_ex_pipe.

Test Plan:
- Reset: hold Rst=0 with random ID inputs, then release → all EX_* = 0, EX_Valid=0, BubbleCount=0, LoadUseStall=0.
- Pass-through: ID R-type (RegDst=1, RegWrite=1, ALUOp=10, Rs=8, Rt=9, Rd=10, ReadData1=0x1234) → next cycle EX fields equal ID values and EX_Valid=1.
- Load-use:
  - Stimulus: EX holds LW with Rt=9 and MemRead=1; ID holds R-type with Rs=9.
  - Response: LoadUseStall=1; next edge EX_Valid=0 and BubbleCount=1; following cycle LoadUseStall=0 and the R-type enters EX.
- Non-hazards: repeat the load-use setup with EX_Rt=0, or with ID_Rt=9 and ID_UsesRt=0 → LoadUseStall=0 and no bubble.
- Priority:
  - Flush=1 with Stall=1 → bubble and count increments.
  - Stall=1 with LoadUseStall=1 → EX unchanged and count unchanged.
- Saturation: preload via 65535 forced bubbles, then Flush again → BubbleCount stays 0xFFFF.
